serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
Asynchronous serial transmitter: the transmit end of the lab's serial link. Frames each byte as start bit, LSB-first data, optional parity and stop bit. Uses the same 16x-oversample tick as the receive path, so each bit lasts exactly OVERSAMPLE ticks. Sits between the byte producer (valid/ready handshake) and the tx line pin.

Parameters:
DATA_BITS, 8, number of data bits per frame (1..8)
OVERSAMPLE, 16, ticks per bit period (1..16); sub-bit counter is 4 bits wide

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
tick  input  1  one-clk-wide oversample enable (16x baud); sampled every clk
data_in  input  DATA_BITS  byte to transmit; sampled only on the accept edge
load  input  1  producer asserts to request transmission of data_in
ready  output  1  high when a load is accepted this cycle; equals (state == IDLE)
tx  output  1  serial line; idle/mark = 1
busy  output  1  high from the accept edge through the end of the stop bit
done  output  1  one-clk pulse on the edge that ends the stop bit

Behaviour:
- Reset (rst high at posedge): state IDLE, tx=1, busy=0, done=0, ready=1, sub-counter=0, bit index=0, shift register=0. Reset has priority over every other input, including mid-frame; the frame is abandoned and tx returns to 1 on that edge.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: tx=1. On an edge with load=1: latch data_in into the shift register; go to START; tx<=0; busy<=1; sub-counter<=0; bit index<=0. tick is ignored in IDLE, so bit timing starts at the first tick after acceptance.
- Bit timing: a 4-bit sub-counter advances only on edges with tick=1. On a tick edge with sub-counter==OVERSAMPLE-1, the current bit ends: the sub-counter wraps to 0 and the state advances. Otherwise the sub-counter increments. Each bit therefore holds for exactly OVERSAMPLE tick edges.
- START end: go to DATA; tx<=shift[0].
- DATA end: if bit index < DATA_BITS-1, shift right, increment bit index, and drive tx<=the next LSB. Otherwise go to PARITY when the feature is enabled, else go to STOP with tx<=1.
- STOP end: go to IDLE; busy<=0; done<=1 for one clk; tx stays 1.
- done is 0 on all other cycles.
- Frame length: (2 + DATA_BITS [+1]) * OVERSAMPLE tick edges.
- load while busy: ignored; data_in is not re-sampled.
- Back-to-back frames: ready=1 on the cycle after done, so the earliest next accept is the edge after done, giving a minimum of 1 clk of idle-high.
- tick and load both high in IDLE: the load is accepted; that tick does not count toward the start bit.
- tick held high continuously: legal; each bit then lasts OVERSAMPLE clks.
- data_in changes after acceptance: no effect on the current frame.
- All outputs are registered except ready, which is decoded from the state register only and never from load.

Optional Feature:
Macro SERIAL_TX_PARITY_EN.
- Defined: PARITY state inserted after the last data bit. tx = even parity, i.e. the XOR of the latched data_in bits, computed at accept time and held in a register. PARITY lasts OVERSAMPLE ticks and is followed by STOP. Frame length is (3 + DATA_BITS) * OVERSAMPLE ticks.
- Undefined: no PARITY state and no parity register; DATA goes directly to STOP.

Test Plan:
- Reset: rst=1 for 2 clks with load=1 -> tx=1, busy=0, done=0, ready=1; no frame starts.
- Single frame: tick high every clk, OVERSAMPLE=16, load 0xA5 -> tx low for 16 clks, then bits 1,0,1,0,0,1,0,1, each 16 clks, then stop high for 16 clks. done pulses once at clk 160 after accept; busy is high for exactly 160 clks.
- Sparse tick: tick every 4th clk, load 0x3C -> every bit lasts 64 clks; total busy 640 clks; bit order 0,0,1,1,1,1,0,0.
- Load while busy: load 0x55 mid-frame of 0xA5 -> waveform is identical to the 0xA5-only case; 0x55 is never sent.
- Back-to-back: load held high continuously with 0x01 then 0xFF -> second start bit begins on the edge after done; idle gap is exactly 1 clk.
- Reset mid-frame: rst=1 during DATA bit 3 -> tx=1 and busy=0 on that edge, no done pulse. The next load 0x0F produces a clean full frame. With SERIAL_TX_PARITY_EN: 0x0F gives parity 0, 0x07 gives parity 1, and each frame is 176 clks with tick every clk.

Source files
------------

// File: rtl/serial_tx.sv
// Asynchronous serial transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Optional parity bit enabled by defining SERIAL_TX_PARITY_EN.
module serial_tx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 load,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic parity_q, parity_d;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state_q, state_d;
    logic [3:0]           sub_q, sub_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, shr;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sub_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sub_q    <= sub_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        sub_d    = sub_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        shr      = shift_q >> 1;
        bit_end  = tick && (sub_q == 4'(OVERSAMPLE - 1));
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q == IDLE) begin
            // tick is deliberately ignored here so the start bit gets a full period
            tx_d = 1'b1;
            if (load) begin
                shift_d  = data_in;
                state_d  = START;
                tx_d     = 1'b0;
                busy_d   = 1'b1;
                sub_d    = '0;
                idx_d    = '0;
`ifdef SERIAL_TX_PARITY_EN
                parity_d = ^data_in;
`endif
            end
        end else if (tick) begin
            sub_d = bit_end ? 4'd0 : sub_q + 4'd1;
            if (bit_end) begin
                case (state_q)
                    START: begin
                        state_d = DATA;
                        tx_d    = shift_q[0];
                    end
                    DATA: begin
                        if (idx_q < IW'(DATA_BITS - 1)) begin
                            shift_d = shr;
                            idx_d   = idx_q + IW'(1);
                            tx_d    = shr[0];
                        end else begin
`ifdef SERIAL_TX_PARITY_EN
                            state_d = PARITY;
                            tx_d    = parity_q;
`else
                            state_d = STOP;
                            tx_d    = 1'b1;
`endif
                        end
                    end
`ifdef SERIAL_TX_PARITY_EN
                    PARITY: begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
`endif
                    STOP: begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    assign ready = (state_q == IDLE);
    assign tx    = tx_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Randomized bench for serial_tx against a frame-level bit-list model.
module tb_serial_tx;

    localparam int DB = 8;
    localparam int OS = 16;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NP = 1;
`else
    localparam int NP = 0;
`endif
    localparam int FLEN = 2 + DB + NP;

    logic          clk = 1'b0;
    logic          rst, tick, load;
    logic [DB-1:0] data_in;
    logic          ready, tx, busy, done;

    int n_chk = 0;
    int n_err = 0;

    // reference model: a frame is a list of line levels, indexed by ticks/OS
    logic m_bits [0:FLEN-1];
    bit   m_busy = 1'b0;
    bit   m_done = 1'b0;
    bit   m_tx   = 1'b1;
    int   m_ticks = 0;
    int   n_busy, n_done, n_frames;

    serial_tx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .tick(tick), .data_in(data_in), .load(load),
        .ready(ready), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit t, input bit l, input logic [DB-1:0] d);
        m_done = 1'b0;
        if (r) begin
            m_busy = 1'b0;
            m_tx   = 1'b1;
        end else if (!m_busy) begin
            m_tx = 1'b1;
            if (l) begin
                m_bits[0] = 1'b0;
                for (int i = 0; i < DB; i++) m_bits[1+i] = d[i];
                if (NP == 1) m_bits[1+DB] = ^d;
                m_bits[FLEN-1] = 1'b1;
                m_busy  = 1'b1;
                m_ticks = 0;
                m_tx    = 1'b0;
                n_frames++;
            end
        end else if (t) begin
            m_ticks++;
            if (m_ticks == FLEN * OS) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_tx   = 1'b1;
            end else begin
                m_tx = m_bits[m_ticks / OS];
            end
        end
    endtask

    task automatic step(input bit r, input bit t, input bit l, input logic [DB-1:0] d);
        rst = r; tick = t; load = l; data_in = d;
        @(posedge clk);
        model_edge(r, t, l, d);
        #1;
        check("tx", tx, m_tx);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("ready", ready, !m_busy);
        if (busy) n_busy++;
        if (done) n_done++;
    endtask

    task automatic clr_cnt();
        n_busy = 0; n_done = 0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; load = 1'b0; data_in = '0;
        n_frames = 0;

        // reset with load asserted: no frame may start
        clr_cnt();
        step(1, 1, 1, 8'hA5);
        step(1, 1, 1, 8'hA5);
        check("rst_busy_cnt", n_busy, 0);
        step(0, 0, 0, 8'h00);

        // single frame, tick every clk
        clr_cnt();
        step(0, 1, 1, 8'hA5);
        for (int i = 0; i < FLEN * OS + 8; i++) step(0, 1, 0, 8'h00);
        check("single_busy_len", n_busy, FLEN * OS);
        check("single_done_cnt", n_done, 1);

        // sparse tick, every 4th clk
        clr_cnt();
        step(0, 0, 1, 8'h3C);
        for (int i = 1; i <= FLEN * OS * 4 + 8; i++) step(0, (i % 4) == 0, 0, 8'h00);
        check("sparse_busy_len", n_busy, FLEN * OS * 4);
        check("sparse_done_cnt", n_done, 1);

        // load while busy is ignored
        clr_cnt();
        step(0, 1, 1, 8'hA5);
        for (int i = 0; i < FLEN * OS + 8; i++) step(0, 1, (i >= 40 && i < 60), 8'h55);
        check("ovl_done_cnt", n_done, 1);

        // back-to-back with load held high
        clr_cnt();
        step(0, 1, 1, 8'h01);
        for (int i = 0; i < FLEN * OS; i++) step(0, 1, 1, 8'hFF);
        check("b2b_first_done", done, 1);
        step(0, 1, 1, 8'hFF);
        check("b2b_restart_busy", busy, 1);
        check("b2b_restart_tx", tx, 0);
        for (int i = 0; i < FLEN * OS + 4; i++) step(0, 1, 0, 8'h00);
        check("b2b_done_cnt", n_done, 2);

        // reset during data bit 3, then clean frames
        clr_cnt();
        step(0, 1, 1, 8'hA5);
        for (int i = 0; i < 4 * OS + 5; i++) step(0, 1, 0, 8'h00);
        step(1, 1, 0, 8'h00);
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done_cnt", n_done, 0);
        step(0, 1, 1, 8'h0F);
        for (int i = 0; i < FLEN * OS + 2; i++) step(0, 1, 0, 8'h00);
        step(0, 1, 1, 8'h07);
        for (int i = 0; i < FLEN * OS + 2; i++) step(0, 1, 0, 8'h00);
        check("midrst_frames_done", n_done, 2);

        // randomized traffic with varying tick density and rare resets
        for (int ph = 0; ph < 6; ph++) begin
            int dens;
            dens = $urandom_range(1, 4);
            for (int i = 0; i < 1500; i++)
                step($urandom_range(0, 1999) == 0,
                     $urandom_range(1, dens) == 1,
                     $urandom_range(0, 3) == 0,
                     DB'($urandom));
        end
        check("frames_sent_nonzero", n_frames > 10, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
